// File: rtl/fft_root_scan_if.sv
// fft_root_scan_if: bus bundle between the root scanner and its neighbours.
//   Read port (toward FFT evaluation memory): rd_en, rd_addr, rd_data.
//   Flag stream (toward consumer):           out_valid, out_ready, out_addr, out_bits.
// master = the scanner, slave = memory + downstream consumer.
interface fft_root_scan_if #(
  parameter int unsigned gf        = 13,
  parameter int unsigned mem_width = 64,
  parameter int unsigned dep_bits  = 6
);
  logic                      rd_en;
  logic [dep_bits-1:0]       rd_addr;
  logic [2*mem_width*gf-1:0] rd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [dep_bits-1:0]       out_addr;
  logic [2*mem_width-1:0]    out_bits;

  modport master (
    output rd_en, rd_addr, out_valid, out_addr, out_bits,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_addr, out_bits,
    output rd_data, out_ready
  );
endinterface

// File: rtl/fft_root_scan.sv
// fft_root_scan: sweeps the FFT evaluation memory after a transform, flags every
// zero evaluation (root of the error locator) below n_len and streams one flag
// word per address over a valid/ready handshake, accumulating the root count.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      single-cycle pulse, accepted only when idle
//   bus        read port + flag stream (fft_root_scan_if.master)
//   root_cnt   roots flagged so far in the current scan
//   busy       high whenever not idle
//   done       one-cycle pulse at scan end
module fft_root_scan #(
  parameter int unsigned gf        = 13,
  parameter int unsigned mem_width = 64,
  parameter int unsigned dep_bits  = 6,
  parameter int unsigned n_len     = 3488
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fft_root_scan_if.master       bus,
  output logic [gf:0]           root_cnt,
  output logic                  busy,
  output logic                  done
);
  localparam int unsigned Lanes     = 2 * mem_width;
  localparam int unsigned LastWord  = (n_len + Lanes - 1) / Lanes - 1;
  // Valid lanes in the final, partially used word.
  localparam int unsigned LastLanes = n_len - LastWord * Lanes;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e              state_q;
  logic [dep_bits-1:0] issue_q;
  logic                inflight_q;
  logic [dep_bits-1:0] inflight_addr_q;
  logic [dep_bits-1:0] fifo_addr_q [2];
  logic [Lanes-1:0]    fifo_bits_q [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          count_q;
  logic [gf:0]         root_cnt_q;
  logic                busy_q;
  logic                done_q;

  logic                pop;
  logic [1:0]          occ;
  logic                rd_en;
  logic                drain_done;
  logic [Lanes-1:0]    flags;
  logic [gf:0]         flag_cnt;

  always_comb begin
    pop = (count_q != 2'd0) & bus.out_ready;
    // Committed entries after this edge; issuing only below 2 bounds the FIFO.
    occ = count_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_en = (state_q == StScan) && (occ < 2'd2);
    drain_done = !inflight_q && (count_q == {1'b0, pop});
  end

  always_comb begin
    flags    = '0;
    flag_cnt = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      flags[i] = (bus.rd_data[i*gf +: gf] == '0) &&
                 ((inflight_addr_q != dep_bits'(LastWord)) || (i < LastLanes));
      flag_cnt = flag_cnt + {{gf{1'b0}}, flags[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      issue_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      fifo_addr_q[0]  <= '0;
      fifo_addr_q[1]  <= '0;
      fifo_bits_q[0]  <= '0;
      fifo_bits_q[1]  <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
      root_cnt_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= rd_en;
      inflight_addr_q <= issue_q;
      count_q         <= occ;
      if (rd_en) issue_q <= issue_q + 1'b1;
      if (inflight_q) begin
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        fifo_bits_q[wr_ptr_q] <= flags;
        wr_ptr_q              <= ~wr_ptr_q;
        root_cnt_q            <= root_cnt_q + flag_cnt;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StScan;
            busy_q     <= 1'b1;
            issue_q    <= '0;
            root_cnt_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
          end
        end
        StScan: begin
          if (rd_en && (issue_q == dep_bits'(LastWord))) state_q <= StDrain;
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = issue_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_addr  = fifo_addr_q[rd_ptr_q];
  assign bus.out_bits  = fifo_bits_q[rd_ptr_q];
  assign root_cnt      = root_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_fft_root_scan.sv
module tb_fft_root_scan;
  localparam int Words = 28;
  localparam int Lanes = 128;
  localparam int NLen  = 3488;
  localparam int Pos   = Words * Lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] root_cnt;
  logic        busy;
  logic        done;

  fft_root_scan_if bus ();

  fft_root_scan dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .root_cnt (root_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Evaluation memory model: one 13-bit evaluation per code position.
  logic [12:0]      lanes [Pos];
  logic [Lanes-1:0] exp_bits [Words];
  int               exp_root;
  int               last_root;
  int               tests = 0;
  int               fails = 0;

  initial bus.rd_data = '0;
  always @(posedge clk) begin
    logic [Lanes*13-1:0] w;
    w = '0;
    if (bus.rd_en) begin
      for (int i = 0; i < Lanes; i++) begin
        int idx;
        idx = int'(bus.rd_addr) * Lanes + i;
        if (idx < Pos) w[i*13 +: 13] = lanes[idx];
      end
      bus.rd_data <= w;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // 0: all nonzero, 1: all zero, 2: sparse zeros, 3: random with many zeros
  task automatic fill(input int kind);
    for (int p = 0; p < Pos; p++) begin
      case (kind)
        0: lanes[p] = 13'h1;
        1: lanes[p] = 13'h0;
        2: lanes[p] = (p == 0 || p == 127 || p == 128 || p == 3487 || p == 3488) ? 13'h0
                                                                                 : 13'h1;
        default: lanes[p] = ($urandom_range(0, 3) == 0) ? 13'h0
                                                         : 13'($urandom_range(1, 8191));
      endcase
    end
    exp_root = 0;
    for (int a = 0; a < Words; a++) exp_bits[a] = '0;
    for (int p = 0; p < NLen; p++) begin
      if (lanes[p] == 13'h0) begin
        exp_bits[p / Lanes][p % Lanes] = 1'b1;
        exp_root++;
      end
    end
  endtask

  // One scan. ready_rand: random out_ready with a low stretch; reset_at: cycle of a
  // mid-scan reset (0 = none); stray: extra start pulses during SCAN and DONE.
  task automatic run_scan(input bit ready_rand, input int reset_at, input bit stray);
    int  k = 0;
    int  issued = 0;
    int  accepted = 0;
    bit  prev_stall = 1'b0;
    logic [5:0]       prev_addr = '0;
    logic [Lanes-1:0] prev_bits = '0;
    bit  finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (stray && (cyc == 5 || cyc == 31)) ||
              (reset_at != 0 && cyc == reset_at);
      rst   = (reset_at != 0 && cyc == reset_at);
      if (ready_rand) bus.out_ready = (cyc >= 12 && cyc < 22) ? 1'b0
                                                             : ($urandom_range(0, 2) != 0);
      else bus.out_ready = 1'b1;
      #1;
      if (cyc == 0) begin
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_rd_en", 128'(bus.rd_en), 128'(0));
        chk("idle_root_hold", 128'(root_cnt), 128'(last_root));
        continue;
      end
      if (reset_at != 0 && cyc == reset_at + 1) begin
        chk("rst_rd_en", 128'(bus.rd_en), 128'(0));
        chk("rst_rd_addr", 128'(bus.rd_addr), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_addr", 128'(bus.out_addr), 128'(0));
        chk("rst_out_bits", 128'(bus.out_bits), 128'(0));
        chk("rst_root_cnt", 128'(root_cnt), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        last_root = 0;
        finished = 1'b1;
        continue;
      end
      chk("busy", 128'(busy), 128'(1));
      if (prev_stall) begin
        chk("hold_valid", 128'(bus.out_valid), 128'(1));
        chk("hold_addr", 128'(bus.out_addr), 128'(prev_addr));
        chk("hold_bits", 128'(bus.out_bits), 128'(prev_bits));
      end
      if (bus.rd_en) begin
        chk("rd_addr_order", 128'(bus.rd_addr), 128'(issued));
        if (!ready_rand) chk("rd_timing", 128'(cyc), 128'(1 + issued));
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (k < Words) begin
          chk("out_addr", 128'(bus.out_addr), 128'(k));
          chk("out_bits", 128'(bus.out_bits), 128'(exp_bits[k]));
          if (!ready_rand) chk("out_timing", 128'(cyc), 128'(3 + k));
        end else begin
          chk("extra_word", 128'(k), 128'(Words - 1));
        end
        k++;
        accepted++;
      end
      chk("outstanding_le2", 128'(issued - accepted <= 2), 128'(1));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_addr  = bus.out_addr;
      prev_bits  = bus.out_bits;
      if (done) begin
        chk("word_count", 128'(k), 128'(Words));
        chk("root_cnt", 128'(root_cnt), 128'(exp_root));
        if (!ready_rand) chk("done_cycle", 128'(cyc), 128'(31));
        last_root = exp_root;
        finished = 1'b1;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    if (!finished) chk("scan_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    last_root = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd_en", 128'(bus.rd_en), 128'(0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_root_cnt", 128'(root_cnt), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    rst = 1'b0;

    fill(0); run_scan(1'b0, 0, 1'b0);
    fill(1); run_scan(1'b0, 0, 1'b0);
    chk("all_zero_last_word", exp_bits[27], 128'hffff_ffff);
    fill(2); run_scan(1'b0, 0, 1'b0);
    fill(0); run_scan(1'b1, 0, 1'b0);
    fill(3); run_scan(1'b1, 0, 1'b0);
    fill(0); run_scan(1'b0, 10, 1'b0);
    run_scan(1'b0, 0, 1'b0);
    fill(3); run_scan(1'b0, 0, 1'b1);
    fill(3); run_scan(1'b0, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("final_idle_busy", 128'(busy), 128'(0));
    chk("final_root_hold", 128'(root_cnt), 128'(last_root));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_root_scan.md
# fft_root_scan

Reads back the evaluation memory of the additive FFT after a transform completes and turns the evaluations into an error-position bit map. It is the consumer of the FFT's `rd_en`/`rd_addr`/data read port. It sweeps the word addresses, flags every evaluation equal to zero (a root of the error-locator polynomial), masks positions beyond the code length, and streams one flag word per address over a valid/ready handshake. It also accumulates the total root count.

## Interface
- `gf`, 13: field width in bits, i.e. the width of one evaluation.
- `mem_width`, 64: evaluations per memory half; one read word carries `2*mem_width` lanes.
- `dep_bits`, 6: width of the read address.
- `n_len`, 3488: code length; positions `>= n_len` are never flagged.
- `last_word`, derived: `ceil(n_len/(2*mem_width))-1`, which is 27 at defaults.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  single-cycle pulse; only accepted in IDLE.
- `rd_en`  out  1  read strobe to the FFT memory.
- `rd_addr`  out  `dep_bits`  word address; meaningful only while `rd_en` is high.
- `rd_data`  in  `2*mem_width*gf`  read word, valid exactly 1 cycle after `rd_en`; lane i is `rd_data[i*gf +: gf]`.
- `out_valid`  out  1  flag word available.
- `out_ready`  in  1  downstream accepts the flag word.
- `out_addr`  out  `dep_bits`  word address of `out_bits`.
- `out_bits`  out  `2*mem_width`  bit i is 1 iff lane i is zero and `out_addr*2*mem_width+i < n_len`.
- `root_cnt`  out  `gf+1`  number of flagged positions so far in the current scan.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at scan end.

## Operation
- **FSM states:** IDLE, SCAN, DRAIN, DONE.
  - IDLE + `start` → SCAN. On this transition: `root_cnt` := 0, issue counter := 0, FIFO is flushed.
  - SCAN → DRAIN once the read of address `last_word` has been issued.
  - DRAIN → DONE once no read is in flight, the FIFO is empty, and no flag word remains to be handed off.
  - DONE → IDLE unconditionally; `done` is high for exactly this one cycle.
- `start` is ignored outside IDLE.
- **Read issue:** in SCAN, `rd_en` is high with `rd_addr` = issue counter iff `fifo_count + inflight - pop < 2`. Here `pop` = `out_valid & out_ready` in the current cycle. Addresses are issued strictly in increasing order, each exactly once.
- **Return path:** one cycle after `rd_en`, the block performs `2*mem_width` parallel compares against zero, applies the position mask, and writes `{addr, flags}` into a 2-entry FIFO. In the same edge, `root_cnt += popcount(flags)`.
- **Output:** `out_valid` = FIFO non-empty, and `out_addr`/`out_bits` show the FIFO head. `out_addr`/`out_bits` hold while `out_valid & !out_ready`. Words are never dropped or duplicated.
- **Widths:** `root_cnt` cannot overflow, since its maximum is `n_len` and `n_len < 2^(gf+1)`. The mask applies only to word `last_word`.
- **Reset values:** `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_bits`=0, `root_cnt`=0, `busy`=0, `done`=0, state=IDLE, FIFO empty.
- **Reset mid-scan:** everything above applies on the next edge, and any in-flight return is discarded. A `start` asserted in the same cycle as `rst` is ignored.

## Timing
- With `start` high at cycle 0 and `out_ready` held high:
  - `rd_en` is high from cycle 1, with address a at cycle 1+a.
  - Data for address a returns at cycle 2+a.
  - `out_valid` with `out_addr`=a is high at cycle 3+a.
- At defaults, the last handshake is at cycle 30 and `done` is at cycle 31, so the scan takes `last_word+4` cycles from `start`.
- Sustained throughput is 1 word/cycle when `out_ready`=1.
- `root_cnt` is final from the cycle in which `done` is high; it holds until the next accepted `start`.
- `out_ready` may toggle arbitrarily. Issue stalls within the same cycle, so at most 2 entries are ever committed (`fifo_count + inflight <= 2`).

## Test plan
- **All lanes nonzero** (model returns 0x1 everywhere) → 28 words, `out_addr` 0..27 in order, `out_bits`=0 for each, `root_cnt`=0, `done` at cycle 31.
- **All lanes zero** → words 0..26 have `out_bits` all ones; word 27 has only bits [31:0] set. `root_cnt`=3488 = 27*128+32.
- **Zeros at positions 0, 127, 128, 3487, 3488** → flags at (addr 0, bit 0), (0, 127), (1, 0), (27, 31); position 3488 is masked. `root_cnt`=4.
- **Backpressure:** `out_ready` follows a pseudo-random pattern, plus a 10-cycle low stretch mid-scan → identical sequence to the first scenario. The bench asserts that `fifo_count + inflight` never exceeds 2 and that held outputs are stable while stalled.
- **Reset at cycle 10 of a scan** → the next cycle shows all outputs at reset values and `busy`=0. A fresh `start` then reproduces the full first-scenario sequence from address 0.
- **`start` pulsed during SCAN and DONE** → ignored: no address restart and `root_cnt` not cleared. A `start` one cycle after `done` begins a new scan normally.
